// File: rtl/ksa_key_schedule.sv
// RC4 key-scheduling pass over the shared 256-byte S memory.
// Runs a fixed 7-cycle read/read/swap sequence per index i, then pulses finish_ksa.
module ksa_key_schedule #(
  parameter int unsigned KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_ksa,
  input  logic [KEY_LENGTH*8-1:0] secret_key,
  output logic                    finish_ksa,
  output logic [7:0]              s_mem_addr,
  input  logic [7:0]              s_mem_data_read,
  output logic [7:0]              s_mem_data_write,
  output logic                    s_mem_wren
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD_I  = 4'd1;
  localparam logic [3:0] LAT_I = 4'd2;
  localparam logic [3:0] UPD_J = 4'd3;
  localparam logic [3:0] RD_J  = 4'd4;
  localparam logic [3:0] LAT_J = 4'd5;
  localparam logic [3:0] WR_J  = 4'd6;
  localparam logic [3:0] WR_I  = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  logic [3:0]              state_q;
  logic [7:0]              i_q;
  logic [7:0]              j_q;
  logic [7:0]              s_i_q;
  logic [7:0]              s_j_q;
  logic [1:0]              key_idx_q;
  logic [KEY_LENGTH*8-1:0] key_q;
  logic [7:0]              key_byte;

  // Byte 0 of the key is the most-significant byte.
  always_comb begin
    key_byte = 8'h00;
    for (int unsigned k = 0; k < KEY_LENGTH; k++) begin
      if (key_idx_q == 2'(k)) begin
        key_byte = key_q[(KEY_LENGTH-1-k)*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      i_q       <= 8'h00;
      j_q       <= 8'h00;
      s_i_q     <= 8'h00;
      s_j_q     <= 8'h00;
      key_idx_q <= 2'd0;
      key_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ksa) begin
            key_q     <= secret_key;
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            key_idx_q <= 2'd0;
            state_q   <= RD_I;
          end
        end
        RD_I:  state_q <= LAT_I;
        LAT_I: begin
          s_i_q   <= s_mem_data_read;
          state_q <= UPD_J;
        end
        UPD_J: begin
          j_q     <= j_q + s_i_q + key_byte;
          state_q <= RD_J;
        end
        RD_J:  state_q <= LAT_J;
        LAT_J: begin
          s_j_q   <= s_mem_data_read;
          state_q <= WR_J;
        end
        WR_J:  state_q <= WR_I;
        WR_I: begin
          if (i_q == 8'hFF) begin
            state_q <= DONE;
          end else begin
            i_q       <= i_q + 8'd1;
            key_idx_q <= (key_idx_q == 2'(KEY_LENGTH - 1)) ? 2'd0 : key_idx_q + 2'd1;
            state_q   <= RD_I;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_mem_addr       = 8'h00;
    s_mem_data_write = 8'h00;
    s_mem_wren       = 1'b0;
    finish_ksa       = 1'b0;
    case (state_q)
      RD_I, LAT_I: s_mem_addr = i_q;
      RD_J, LAT_J: s_mem_addr = j_q;
      WR_J: begin
        s_mem_addr       = j_q;
        s_mem_data_write = s_i_q;
        s_mem_wren       = 1'b1;
      end
      WR_I: begin
        s_mem_addr       = i_q;
        s_mem_data_write = s_j_q;
        s_mem_wren       = 1'b1;
      end
      DONE:    finish_ksa = 1'b1;
      default: ;
    endcase
  end

endmodule
